// File: rtl/rvh_noc_pkg.sv
// Shared NoC types: decoded flit layout, port directions, VC defaults and
// the common one-hot encoder used across router blocks.
package rvh_noc_pkg;

   localparam int VC_NUM_DEFAULT   = 4;
   localparam int VC_DEPTH_DEFAULT = 4;

   typedef enum logic [2:0] {
      P_LOCAL = 3'd0,
      P_NORTH = 3'd1,
      P_SOUTH = 3'd2,
      P_EAST  = 3'd3,
      P_WEST  = 3'd4
   } io_port_t;

   // Look-ahead output port for the next hop, QoS class, packet framing and tag.
   typedef struct packed {
      io_port_t    la_route;
      logic [1:0]  qos;
      logic        is_head;
      logic        is_tail;
      logic [7:0]  tag;
   } flit_dec_t;

   // OR-reduction encoder: exact for one-hot inputs, zero for an all-zero input.
   function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/vc_ctrl_fifo.sv
// Single-VC circular flit FIFO with a combinational head read and an
// occupancy counter; a pop on a full FIFO frees the slot for a same-cycle push.
module vc_ctrl_fifo
   import rvh_noc_pkg::*;
#(
   parameter int DEPTH = VC_DEPTH_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  flit_dec_t                  push_data,
   input  logic                       pop,
   output flit_dec_t                  head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   flit_dec_t          mem [DEPTH];
   logic [PTR_W-1:0]   wptr_reg, rptr_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               push_fire, pop_fire;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CNT_W'(DEPTH));
   assign pop_fire  = pop & ~empty;
   assign push_fire = push & (~full | pop_fire);

   always_comb begin
      count_next = count_reg;
      case ({push_fire, pop_fire})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_fire) wptr_reg <= wptr_reg + 1'b1;
         if (pop_fire)  rptr_reg <= rptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // Storage carries no reset; entries are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_fire) mem[wptr_reg] <= push_data;
   end

   assign head  = mem[rptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/input_vc_ctrl_buf.sv
// Input-port VC buffer: demuxes upstream flits into per-VC FIFOs, exposes
// every VC head to the switch allocator, pops the granted VC and returns credits.
module input_vc_ctrl_buf
   import rvh_noc_pkg::*;
#(
   parameter int VC_NUM   = VC_NUM_DEFAULT,
   parameter int VC_DEPTH = VC_DEPTH_DEFAULT,
   parameter int VC_ID_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
)
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               rx_flit_vld_i,
   input  logic [VC_ID_W-1:0] rx_flit_vc_id_i,
   input  flit_dec_t          rx_flit_i,
   output logic [VC_NUM-1:0]  vc_ctrl_head_vld_o,
   output flit_dec_t          vc_ctrl_head_o [VC_NUM],
   input  logic               inport_read_enable_sa_stage_i,
   input  logic [VC_NUM-1:0]  inport_read_vc_id_oh_i,
   output logic               tx_lcrd_v_o,
   output logic [VC_ID_W-1:0] tx_lcrd_id_o,
   output logic               err_overflow_o,
   output logic               err_underflow_o
);

   localparam int CNT_W = $clog2(VC_DEPTH+1);

   logic [VC_NUM-1:0]  push_req, push_ok, pop_ok, full, empty;
   logic [CNT_W-1:0]   count_w [VC_NUM];
   logic               id_in_range, sel_onehot, pop_any;
   logic               ovf_event, udf_event;
   logic [VC_ID_W-1:0] pop_idx;
   logic               ovf_reg, udf_reg, crd_v_reg;
   logic [VC_ID_W-1:0] crd_id_reg;

   assign id_in_range = (32'(rx_flit_vc_id_i) < 32'(VC_NUM));
   assign sel_onehot  = $onehot(inport_read_vc_id_oh_i);

   genvar gi;
   generate
      for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
         assign push_req[gi] = rx_flit_vld_i & id_in_range
                             & (rx_flit_vc_id_i == VC_ID_W'(gi));
         // A malformed select must not pop anything, even its set bits.
         assign pop_ok[gi]   = inport_read_enable_sa_stage_i & sel_onehot
                             & inport_read_vc_id_oh_i[gi] & ~empty[gi];
         assign push_ok[gi]  = push_req[gi] & (~full[gi] | pop_ok[gi]);

         vc_ctrl_fifo #(
            .DEPTH (VC_DEPTH)
         ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (push_ok[gi]),
            .push_data (rx_flit_i),
            .pop       (pop_ok[gi]),
            .head      (vc_ctrl_head_o[gi]),
            .count     (count_w[gi]),
            .full      (full[gi]),
            .empty     (empty[gi])
         );

         assign vc_ctrl_head_vld_o[gi] = (count_w[gi] != '0);
      end
   endgenerate

   assign pop_any   = |pop_ok;
   assign ovf_event = rx_flit_vld_i & ~(|push_ok);
   assign udf_event = inport_read_enable_sa_stage_i & ~pop_any;
   assign pop_idx   = VC_ID_W'(onehot_to_idx(32'(pop_ok)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_reg    <= 1'b0;
         udf_reg    <= 1'b0;
         crd_v_reg  <= 1'b0;
         crd_id_reg <= '0;
      end else begin
         ovf_reg   <= ovf_reg | ovf_event;
         udf_reg   <= udf_reg | udf_event;
         crd_v_reg <= pop_any;
         if (pop_any) crd_id_reg <= pop_idx;
      end
   end

   assign tx_lcrd_v_o     = crd_v_reg;
   assign tx_lcrd_id_o    = crd_id_reg;
   assign err_overflow_o  = ovf_reg;
   assign err_underflow_o = udf_reg;

endmodule

// File: tb/tb_input_vc_ctrl_buf.sv
// Bench for input_vc_ctrl_buf: directed table, corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_input_vc_ctrl_buf;
   import rvh_noc_pkg::*;

   localparam int NV = 4;
   localparam int DEPTH = 4;
   localparam int FW = $bits(flit_dec_t);

   logic            clk = 1'b0;
   logic            rstn;
   logic            rx_vld;
   logic [1:0]      rx_id;
   flit_dec_t       rx_flit;
   logic [NV-1:0]   head_vld;
   flit_dec_t       head [NV];
   logic            rd_en;
   logic [NV-1:0]   rd_oh;
   logic            crd_v;
   logic [1:0]      crd_id;
   logic            err_ovf, err_udf;

   always #5 clk = ~clk;

   input_vc_ctrl_buf #(.VC_NUM(NV), .VC_DEPTH(DEPTH)) dut (
      .clk                           (clk),
      .rstn                          (rstn),
      .rx_flit_vld_i                 (rx_vld),
      .rx_flit_vc_id_i               (rx_id),
      .rx_flit_i                     (rx_flit),
      .vc_ctrl_head_vld_o            (head_vld),
      .vc_ctrl_head_o                (head),
      .inport_read_enable_sa_stage_i (rd_en),
      .inport_read_vc_id_oh_i        (rd_oh),
      .tx_lcrd_v_o                   (crd_v),
      .tx_lcrd_id_o                  (crd_id),
      .err_overflow_o                (err_ovf),
      .err_underflow_o               (err_udf)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: one queue per VC plus sticky flags and expected credit.
   flit_dec_t q [NV][$];
   bit        m_ovf, m_udf, m_cv;
   int        m_cid;

   function automatic flit_dec_t mk(input logic [7:0] t);
      flit_dec_t f;
      f.la_route = P_EAST;
      f.qos      = t[1:0];
      f.is_head  = t[0];
      f.is_tail  = t[1];
      f.tag      = t;
      return f;
   endfunction

   function automatic logic [31:0] fb(input flit_dec_t f);
      logic [31:0] r;
      r = '0;
      r[FW-1:0] = f;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int v = 0; v < NV; v++) q[v].delete();
      m_ovf = 0; m_udf = 0; m_cv = 0; m_cid = 0;
   endtask

   task automatic model_step(input logic vld, input logic [1:0] id, input flit_dec_t f,
                             input logic rd, input logic [3:0] oh);
      int  pv;
      bit  pop_ok, push_ok;
      pv = -1;
      pop_ok = 0;
      push_ok = 0;
      if (rd && $countones(oh) == 1) begin
         for (int v = 0; v < NV; v++) if (oh[v]) pv = v;
         pop_ok = (q[pv].size() > 0);
      end
      if (rd && !pop_ok) m_udf = 1;
      if (vld) begin
         if (int'(id) >= NV) m_ovf = 1;
         else if (q[id].size() < DEPTH || (pop_ok && pv == int'(id))) push_ok = 1;
         else m_ovf = 1;
      end
      if (pop_ok) void'(q[pv].pop_front());
      if (push_ok) q[id].push_back(f);
      m_cv = pop_ok;
      if (pop_ok) m_cid = pv;
   endtask

   task automatic check_model();
      logic [NV-1:0] ev;
      for (int v = 0; v < NV; v++) ev[v] = (q[v].size() != 0);
      chk("head_vld", 32'(head_vld), 32'(ev));
      for (int v = 0; v < NV; v++)
         if (q[v].size() != 0) chk($sformatf("head[%0d]", v), fb(head[v]), fb(q[v][0]));
      chk("crd_v", 32'(crd_v), 32'(m_cv));
      if (m_cv) chk("crd_id", 32'(crd_id), 32'(m_cid));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_udf", 32'(err_udf), 32'(m_udf));
   endtask

   task automatic cycle(input logic vld, input logic [1:0] id, input flit_dec_t f,
                        input logic rd, input logic [3:0] oh);
      @(negedge clk);
      rx_vld = vld; rx_id = id; rx_flit = f; rd_en = rd; rd_oh = oh;
      @(posedge clk);
      model_step(vld, id, f, rd, oh);
      #1;
      check_model();
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] t);
      cycle(1'b1, id, mk(t), 1'b0, 4'b0000);
   endtask

   task automatic pop(input logic [3:0] oh);
      cycle(1'b0, 2'd0, mk(8'h00), 1'b1, oh);
   endtask

   task automatic idle();
      cycle(1'b0, 2'd0, mk(8'h00), 1'b0, 4'b0000);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic apply_reset();
      @(negedge clk);
      rx_vld = 0; rd_en = 0; rd_oh = '0;
      #2 rstn = 1'b0;
      #1;
      model_clear();
      check_model();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   typedef struct {
      logic        vld;
      logic [1:0]  id;
      logic [7:0]  tag;
      logic        rd;
      logic [3:0]  oh;
      logic [3:0]  e_hvld;
      logic        chk_h;
      logic [7:0]  e_tag;
      logic        e_cv;
      logic [1:0]  e_cid;
   } vec_t;

   vec_t tbl [6];
   int   crd_cnt;
   int   r;
   logic [FW-1:0] rbits;
   logic [3:0] roh;

   initial begin
      // VC2: push A, push B, pop, pop, idle (A=0xA1, B=0xB2)
      tbl[0] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 2'd2, 8'hA1, 1'b0, 4'b0000, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd0};
      tbl[2] = '{1'b1, 2'd2, 8'hB2, 1'b0, 4'b0000, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd0};
      tbl[3] = '{1'b0, 2'd0, 8'h00, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hB2, 1'b1, 2'd2};
      tbl[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2};
      tbl[5] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

      rstn = 1'b0; rx_vld = 0; rx_id = 0; rx_flit = mk(8'h00); rd_en = 0; rd_oh = '0;
      model_clear();
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].vld, tbl[i].id, mk(tbl[i].tag), tbl[i].rd, tbl[i].oh);
         chk($sformatf("tbl%0d hvld", i), 32'(head_vld), 32'(tbl[i].e_hvld));
         if (tbl[i].chk_h) chk($sformatf("tbl%0d head2", i), fb(head[2]), fb(mk(tbl[i].e_tag)));
         chk($sformatf("tbl%0d crd_v", i), 32'(crd_v), 32'(tbl[i].e_cv));
         if (tbl[i].e_cv) chk($sformatf("tbl%0d crd_id", i), 32'(crd_id), 32'(tbl[i].e_cid));
         chk($sformatf("tbl%0d errs", i), 32'({err_ovf, err_udf}), 32'(0));
      end

      // VC1 full, simultaneous push C and pop: accepted, one credit, no error
      for (int i = 0; i < 4; i++) push(2'd1, 8'hB0 + 8'(i));
      cycle(1'b1, 2'd1, mk(8'hCC), 1'b1, 4'b0010);
      chk("full_pp crd_v", 32'(crd_v), 32'(1));
      chk("full_pp crd_id", 32'(crd_id), 32'(1));
      chk("full_pp ovf", 32'(err_ovf), 32'(0));
      for (int i = 0; i < 4; i++) begin
         chk("full_pp order", fb(head[1]), fb(mk(i < 3 ? 8'hB1 + 8'(i) : 8'hCC)));
         pop(4'b0010);
      end
      chk("full_pp drained", 32'(head_vld[1]), 32'(0));

      // VC0 overflow: 5th push dropped, 4 pops return A0..A3
      for (int i = 0; i < 5; i++) push(2'd0, 8'h50 + 8'(i));
      chk("ovf flag", 32'(err_ovf), 32'(1));
      for (int i = 0; i < 4; i++) begin
         chk("ovf order", fb(head[0]), fb(mk(8'h50 + 8'(i))));
         pop(4'b0001);
      end
      chk("ovf drained", 32'(head_vld[0]), 32'(0));

      // Mid-operation reset flushes; then multi-hot pop leaves state alone
      push(2'd2, 8'h77);
      apply_reset();
      chk("flush hvld", 32'(head_vld), 32'(0));
      push(2'd1, 8'h61);
      push(2'd2, 8'h62);
      pop(4'b0110);
      chk("mhot udf", 32'(err_udf), 32'(1));
      chk("mhot crd", 32'(crd_v), 32'(0));
      chk("mhot hvld", 32'(head_vld), 32'(4'b0110));
      apply_reset();
      pop(4'b1000);
      chk("empty udf", 32'(err_udf), 32'(1));
      chk("empty crd", 32'(crd_v), 32'(0));

      // Pointer wrap through VC3
      apply_reset();
      crd_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         push(2'd3, 8'h30 + 8'(i));
         chk("wrap head", fb(head[3]), fb(mk(8'h30 + 8'(i))));
         pop(4'b1000);
         if (crd_v && crd_id == 2'd3) crd_cnt++;
      end
      chk("wrap credits", 32'(crd_cnt), 32'(10));
      chk("wrap errs", 32'({err_ovf, err_udf}), 32'(0));

      // Random traffic against the model
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 8) roh = 4'b0001 << $urandom_range(0, 3);
         else if (r == 8) roh = 4'b0000;
         else roh = 4'($urandom);
         rbits = FW'($urandom);
         cycle(1'($urandom), 2'($urandom), flit_dec_t'(rbits), 1'($urandom), roh);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/input_vc_ctrl_buf.md
# input_vc_ctrl_buf

Per-input-port virtual-channel control buffer: accepts decoded flits from the upstream link, stores them in one circular FIFO per VC, presents every VC's head flit and valid to the local switch allocator, and pops the granted VC when the SA stage reads the input port. Each pop returns one credit to the upstream router. It is the producer side of the local SA head interface: it generates `vc_ctrl_head_vld`/`vc_ctrl_head`, and it consumes the SA-stage read enable that the allocator's round-robin pointer also uses.

## Interface
- `VC_NUM`, default 4: number of VCs on this input port (≥1).
- `VC_DEPTH`, default 4: flit entries per VC (power of 2, ≥2).
- `VC_ID_W`, default `VC_NUM>1 ? $clog2(VC_NUM) : 1`: VC index width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx_flit_vld_i`  in  1  incoming flit valid.
- `rx_flit_vc_id_i`  in  `VC_ID_W`  target VC of the incoming flit.
- `rx_flit_i`  in  `flit_dec_t`  decoded flit (look-ahead routing, QoS, payload control).
- `vc_ctrl_head_vld_o`  out  `VC_NUM`  VC FIFO non-empty.
- `vc_ctrl_head_o`  out  `VC_NUM` x `flit_dec_t`  head entry of each VC.
- `inport_read_enable_sa_stage_i`  in  1  SA stage pops one flit this cycle.
- `inport_read_vc_id_oh_i`  in  `VC_NUM`  one-hot VC being popped.
- `tx_lcrd_v_o`  out  1  credit return valid to upstream.
- `tx_lcrd_id_o`  out  `VC_ID_W`  VC of the returned credit.
- `err_overflow_o`  out  1  sticky: push was dropped into a full VC.
- `err_underflow_o`  out  1  sticky: pop of an empty VC, or a non-one-hot pop select.

## Operation
- Per VC: storage `VC_DEPTH` x `flit_dec_t`, write pointer and read pointer of `$clog2(VC_DEPTH)` bits that wrap modulo `VC_DEPTH`, and an occupancy counter of `$clog2(VC_DEPTH+1)` bits.
- Push: `rx_flit_vld_i` writes `rx_flit_i` to the `rx_flit_vc_id_i` entry at `wptr`, then `wptr`++ and count++.
- Pop: `inport_read_enable_sa_stage_i & inport_read_vc_id_oh_i[v] & (count[v]!=0)` advances `rptr[v]` and decrements count.
- Same VC, push and pop in the same cycle: both take effect and count is unchanged. This holds even when the VC is full, because the pop frees the slot.
- Push to a full VC with no same-cycle pop: flit dropped, pointers unchanged, `err_overflow_o` set.
- Pop request when the selected VC is empty, or when the select is zero-hot or multi-hot while `inport_read_enable_sa_stage_i` is high: no state change, `err_underflow_o` set.
- `rx_flit_vc_id_i` ≥ `VC_NUM`: flit dropped, `err_overflow_o` set.
- Head path:
  - `vc_ctrl_head_vld_o[v] = (count[v]!=0)`.
  - `vc_ctrl_head_o[v] = mem[v][rptr[v]]`, combinational from storage.
  - There is no bypass from `rx_flit_i`.
- Credit: each successful pop registers `tx_lcrd_v_o=1` and `tx_lcrd_id_o` = binary index of the popped VC, for exactly one cycle. At most one credit per cycle, because pops are one per cycle.
- Error flags clear only on reset.

## Timing
- Reset values:
  - All counts and pointers are 0.
  - `vc_ctrl_head_vld_o` = 0, `tx_lcrd_v_o` = 0, `tx_lcrd_id_o` = 0, both error flags = 0.
  - Storage is not reset. `vc_ctrl_head_o` is don't-care while its valid is 0.
- Push to head latency: a flit pushed at edge N is visible on `vc_ctrl_head_*` after edge N (1 cycle).
- Pop takes effect at the edge. The next entry, or valid=0, appears in the following cycle.
- Credit latency: the credit appears in the cycle after the pop edge, i.e. registered 1 cycle after the pop cycle.
- Reset asserted mid-operation flushes all VCs immediately (asynchronously). In-flight credits are lost; the upstream credit counter resets in the same domain.

## Structure
- Shared NoC package (`rvh_noc_pkg`) holds `flit_dec_t`, `io_port_t` and the VC count/depth defaults. No new typedefs are local to this block.
- Sub-module `vc_ctrl_fifo`: a single-VC circular FIFO (push, pop, head, count, full, empty), instantiated `VC_NUM` times via generate.
- The top level holds: push demux, one-hot pop decode and one-hot check, error flags, and the credit register.
- One-hot to index conversion reuses the existing codebase encoder.

## Test plan
- Reset then idle: all `vc_ctrl_head_vld_o`=0, `tx_lcrd_v_o`=0, both errors 0.
- Push flits A, B to VC2 in consecutive cycles, then pop VC2 (oh=4'b0100) for 2 cycles:
  - `vc_ctrl_head_o[2]`=A one cycle after the A push.
  - After the first pop the head becomes B.
  - Credits `tx_lcrd_id_o`=2 appear on 2 consecutive cycles; then the VC2 valid drops to 0.
- Fill VC0 with 4 flits, then push a 5th: the flit is dropped and `err_overflow_o`=1. Count stays 4, and 4 pops return A0..A3 in order.
- VC1 full plus simultaneous push C and pop: count stays 4, 1 credit for VC1, no error, and C exits after the 3 older flits.
- Pop with oh=4'b0110, and separately a pop of empty VC3: no state change, `err_underflow_o`=1, no credit.
- Pointer wrap: 10 push/pop pairs through VC3 with depth 4: data order preserved across the wrap and 10 credits returned.
